// File: rtl/cpu_test_sequencer.sv
// cpu_test_sequencer: loads a program into a CPU's instruction memory,
// holds it in reset, runs it, then compares selected registers.

module cpu_test_sequencer #(
    parameter int XLEN        = 32,
    parameter int PROG_DEPTH  = 16,
    parameter int NUM_CHECKS  = 8,
    parameter int CYC_W       = 16,
    parameter int HOLD_CYCLES = 2,
    localparam int PAW = $clog2(PROG_DEPTH),
    localparam int AW  = $clog2((PROG_DEPTH > NUM_CHECKS) ? PROG_DEPTH : NUM_CHECKS),
    localparam int CNW = $clog2(NUM_CHECKS) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_sel,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [XLEN-1:0] cfg_wdata,
    input  logic            start,
    output logic            imem_we,
    output logic [PAW-1:0]  imem_addr,
    output logic [XLEN-1:0] imem_wdata,
    output logic            cpu_reset,
    output logic            cpu_halt,
    output logic [4:0]      dbg_raddr,
    input  logic [XLEN-1:0] dbg_rdata,
    output logic            busy,
    output logic            done,
    output logic [CNW-1:0]  pass_cnt,
    output logic [CNW-1:0]  fail_cnt,
    output logic [CNW-1:0]  first_fail
);

    localparam int CIW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_CHK_ADDR,
        S_CHK_CMP,
        S_DONE
    } state_t;

    state_t state_q;

    // Configuration storage
    logic [XLEN-1:0]       prog_q [PROG_DEPTH];
    logic [XLEN-1:0]       exp_q  [NUM_CHECKS];
    logic [4:0]            reg_q  [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] en_q;
    logic [CYC_W-1:0]      run_cycles_q;

    // Sequencer registers
    logic            imem_we_q;
    logic [PAW-1:0]  imem_addr_q;
    logic [XLEN-1:0] imem_wdata_q;
    logic            cpu_reset_q;
    logic            cpu_halt_q;
    logic [4:0]      dbg_raddr_q;
    logic            busy_q;
    logic            done_q;
    logic [CNW-1:0]  pass_q;
    logic [CNW-1:0]  fail_q;
    logic [CNW-1:0]  first_fail_q;
    logic [CIW-1:0]  chk_idx_q;
    logic [HCW-1:0]  hold_cnt_q;
    logic [CYC_W-1:0] run_cnt_q;

    // Decode of config accesses
    logic           cfg_ok;
    logic           prog_hit;
    logic           chk_hit;
    logic [PAW-1:0] prog_idx;
    logic [CIW-1:0] chk_widx;

    assign cfg_ok   = cfg_we && !reset &&
                      (state_q == S_IDLE || state_q == S_DONE);
    assign prog_hit = ({1'b0, cfg_addr} < (AW + 1)'(PROG_DEPTH));
    assign chk_hit  = ({1'b0, cfg_addr} < (AW + 1)'(NUM_CHECKS));
    assign prog_idx = cfg_addr[PAW-1:0];
    assign chk_widx = cfg_addr[CIW-1:0];

    // Sequencing helpers
    logic            load_last;
    logic [PAW-1:0]  load_nxt;
    logic            hold_last;
    logic            run_last;
    logic            chk_last;
    logic [CIW-1:0]  chk_nxt;
    logic            rd_match;
    logic [CNW-1:0]  ff_new;
    logic            chk_go;
    logic            chk_adv;

    assign load_last = (imem_addr_q == PAW'(PROG_DEPTH - 1));
    assign load_nxt  = imem_addr_q + 1'b1;
    assign hold_last = (hold_cnt_q == HCW'(HOLD_CYCLES - 1));
    assign run_last  = (run_cnt_q == run_cycles_q - 1'b1);
    assign chk_last  = (chk_idx_q == CIW'(NUM_CHECKS - 1));
    assign chk_nxt   = chk_idx_q + 1'b1;
    assign rd_match  = (dbg_rdata == exp_q[chk_idx_q]);
    assign ff_new    = (CNW'(1) << (CNW - 1)) | CNW'(chk_idx_q);

    assign chk_go  = (state_q == S_HOLD && hold_last &&
                      run_cycles_q == '0) ||
                     (state_q == S_RUN && run_last);
    assign chk_adv = (state_q == S_CHK_ADDR && !en_q[chk_idx_q]) ||
                     (state_q == S_CHK_CMP);

    // Reset-cleared config: enable bits and run length
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q         <= '0;
            run_cycles_q <= '0;
        end else if (cfg_ok) begin
            if (cfg_sel == 2'd2 && chk_hit) begin
                en_q[chk_widx] <= cfg_wdata[5];
            end
            if (cfg_sel == 2'd3) begin
                run_cycles_q <= cfg_wdata[CYC_W-1:0];
            end
        end
    end

    // Program words, expected values and register numbers survive reset
    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            if (cfg_sel == 2'd0 && prog_hit) begin
                prog_q[prog_idx] <= cfg_wdata;
            end
            if (cfg_sel == 2'd1 && chk_hit) begin
                exp_q[chk_widx] <= cfg_wdata;
            end
            if (cfg_sel == 2'd2 && chk_hit) begin
                reg_q[chk_widx] <= cfg_wdata[4:0];
            end
        end
    end

    // Main sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            cpu_halt_q   <= 1'b0;
            dbg_raddr_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= '0;
            fail_q       <= '0;
            first_fail_q <= '0;
            chk_idx_q    <= '0;
            hold_cnt_q   <= '0;
            run_cnt_q    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= S_LOAD;
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= '0;
                        imem_wdata_q <= prog_q[0];
                        cpu_reset_q  <= 1'b1;
                        cpu_halt_q   <= 1'b0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= '0;
                        fail_q       <= '0;
                        first_fail_q <= '0;
                    end
                end
                S_LOAD: begin
                    if (load_last) begin
                        state_q    <= S_HOLD;
                        imem_we_q  <= 1'b0;
                        hold_cnt_q <= '0;
                    end else begin
                        imem_addr_q  <= load_nxt;
                        imem_wdata_q <= prog_q[load_nxt];
                    end
                end
                S_HOLD: begin
                    if (!hold_last) begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end else if (run_cycles_q != '0) begin
                        state_q     <= S_RUN;
                        cpu_reset_q <= 1'b0;
                        run_cnt_q   <= '0;
                    end
                end
                S_RUN: begin
                    run_cnt_q <= run_cnt_q + 1'b1;
                end
                S_CHK_ADDR: begin
                    if (en_q[chk_idx_q]) begin
                        state_q <= S_CHK_CMP;
                    end
                end
                S_CHK_CMP: begin
                    if (rd_match) begin
                        pass_q <= pass_q + 1'b1;
                    end else begin
                        fail_q <= fail_q + 1'b1;
                        if (!first_fail_q[CNW-1]) begin
                            first_fail_q <= ff_new;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (chk_go) begin
                state_q     <= S_CHK_ADDR;
                chk_idx_q   <= '0;
                dbg_raddr_q <= reg_q[0];
                cpu_halt_q  <= 1'b1;
            end

            if (chk_adv) begin
                if (chk_last) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end else begin
                    state_q     <= S_CHK_ADDR;
                    chk_idx_q   <= chk_nxt;
                    dbg_raddr_q <= reg_q[chk_nxt];
                end
            end
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign cpu_halt   = cpu_halt_q;
    assign dbg_raddr  = dbg_raddr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass_cnt   = pass_q;
    assign fail_cnt   = fail_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// tb_cpu_test_sequencer: directed scenarios against a tiny CPU model
// that executes the loaded program and serves register reads.

module tb_cpu_test_sequencer;

    localparam logic [31:0] ADDI = 32'h00100113;
    localparam logic [31:0] ADD  = 32'h002101B3;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        start;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        cpu_halt;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;
    logic        busy;
    logic        done;
    logic [3:0]  pass_cnt;
    logic [3:0]  fail_cnt;
    logic [3:0]  first_fail;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpu_test_sequencer #(
        .XLEN(32), .PROG_DEPTH(16), .NUM_CHECKS(8),
        .CYC_W(16), .HOLD_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .start(start),
        .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .cpu_halt(cpu_halt),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
        .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail(first_fail)
    );

    // CPU model: instruction memory, register file, single-cycle core
    logic [31:0] imem_m [16];
    logic [31:0] regs [32];
    logic [3:0]  pc;
    logic [31:0] ins;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    assign ins = imem_m[pc];
    assign rd  = ins[11:7];
    assign rs1 = ins[19:15];
    assign rs2 = ins[24:20];

    always @(posedge clk) begin
        if (imem_we === 1'b1) imem_m[imem_addr] <= imem_wdata;
        if (cpu_reset !== 1'b0) begin
            pc <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (cpu_halt === 1'b0) begin
            pc <= pc + 4'd1;
            if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0 && rd != 5'd0)
                regs[rd] <= regs[rs1] + {{20{ins[31]}}, ins[31:20]};
            else if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 &&
                     ins[31:25] == 7'd0 && rd != 5'd0)
                regs[rd] <= regs[rs1] + regs[rs2];
        end
        dbg_rdata <= regs[dbg_raddr];
    end

    // Observation counters sampled mid-cycle
    int         we_total = 0;
    int         order_err = 0;
    int         rst_low_total = 0;
    int         run_total = 0;
    logic       prev_we = 1'b0;
    logic [3:0] prev_addr = '0;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            we_total++;
            if (imem_addr !== (prev_we ? prev_addr + 4'd1 : 4'd0))
                order_err++;
        end
        prev_we   = (imem_we === 1'b1);
        prev_addr = imem_addr;
        if (cpu_reset === 1'b0) rst_low_total++;
        if (cpu_reset === 1'b0 && cpu_halt === 1'b0) run_total++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] s, input logic [3:0] a,
                             input logic [31:0] d);
        cfg_we = 1'b1; cfg_sel = s; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({imem_we, imem_addr, imem_wdata} !== 37'd0) begin
            n_bad++;
            $display("FAIL rst_imem got %b/%h/%h want 0/0/0",
                     imem_we, imem_addr, imem_wdata);
        end
        n_cmp++;
        if ({cpu_reset, cpu_halt} !== 2'b10) begin
            n_bad++;
            $display("FAIL rst_cpu got rst=%b halt=%b want 1/0",
                     cpu_reset, cpu_halt);
        end
        n_cmp++;
        if ({dbg_raddr, busy, done} !== 7'd0) begin
            n_bad++;
            $display("FAIL rst_status got raddr=%h busy=%b done=%b want 0",
                     dbg_raddr, busy, done);
        end
        n_cmp++;
        if ({pass_cnt, fail_cnt, first_fail} !== 12'd0) begin
            n_bad++;
            $display("FAIL rst_cnt got %h/%h/%h want 0/0/0",
                     pass_cnt, fail_cnt, first_fail);
        end
        reset = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({cpu_reset, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL idle_hold got rst=%b busy=%b want 1/0",
                     cpu_reset, busy);
        end
    endtask

    task automatic test_pass;
        int n;
        int we0;
        int run0;
        cfg_write(2'd3, 4'd0, 32'd4);
        cfg_write(2'd2, 4'd0, 32'h22);
        cfg_write(2'd1, 4'd0, 32'd1);
        cfg_write(2'd2, 4'd1, 32'h23);
        cfg_write(2'd1, 4'd1, 32'd2);
        we0 = we_total;
        run0 = run_total;
        pulse_start();
        n_cmp++;
        if ({imem_we, imem_addr, imem_wdata, busy, done} !==
            {1'b1, 4'd0, ADDI, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL load_first got we=%b a=%h d=%h busy=%b done=%b want 1/0/%h/1/0",
                     imem_we, imem_addr, imem_wdata, busy, done, ADDI);
        end
        wait_done(n);
        n_cmp++;
        if (n !== 32) begin
            n_bad++;
            $display("FAIL pass_latency got %0d want 32", n);
        end
        n_cmp++;
        if (we_total - we0 !== 16 || order_err !== 0) begin
            n_bad++;
            $display("FAIL pass_imem got writes=%0d order_err=%0d want 16/0",
                     we_total - we0, order_err);
        end
        n_cmp++;
        if (run_total - run0 !== 4) begin
            n_bad++;
            $display("FAIL pass_runlen got %0d want 4", run_total - run0);
        end
        n_cmp++;
        if ({pass_cnt, fail_cnt, first_fail} !== {4'd2, 4'd0, 4'd0}) begin
            n_bad++;
            $display("FAIL pass_cnt got %h/%h/%h want 2/0/0",
                     pass_cnt, fail_cnt, first_fail);
        end
        n_cmp++;
        if ({busy, done, cpu_reset, cpu_halt} !== 4'b0101) begin
            n_bad++;
            $display("FAIL pass_done got busy=%b done=%b rst=%b halt=%b want 0/1/0/1",
                     busy, done, cpu_reset, cpu_halt);
        end
        n_cmp++;
        if (imem_m[0] !== ADDI || imem_m[1] !== ADD || imem_m[15] !== NOP) begin
            n_bad++;
            $display("FAIL pass_prog got %h %h %h want %h %h %h",
                     imem_m[0], imem_m[1], imem_m[15], ADDI, ADD, NOP);
        end
    endtask

    task automatic test_fail_entry;
        int n;
        cfg_write(2'd2, 4'd1, 32'h03);
        cfg_write(2'd2, 4'd3, 32'h23);
        cfg_write(2'd1, 4'd3, 32'd5);
        pulse_start();
        wait_done(n);
        n_cmp++;
        if (n !== 32) begin
            n_bad++;
            $display("FAIL fail_latency got %0d want 32", n);
        end
        n_cmp++;
        if ({pass_cnt, fail_cnt, first_fail} !== {4'd1, 4'd1, 4'hB}) begin
            n_bad++;
            $display("FAIL fail_cnt got %h/%h/%h want 1/1/b",
                     pass_cnt, fail_cnt, first_fail);
        end
        cfg_write(2'd2, 4'd1, 32'h23);
        cfg_write(2'd2, 4'd3, 32'h03);
    endtask

    task automatic test_zero_run;
        int n;
        int low0;
        cfg_write(2'd3, 4'd0, 32'd0);
        cfg_write(2'd1, 4'd0, 32'd0);
        cfg_write(2'd2, 4'd1, 32'h03);
        pulse_start();
        low0 = rst_low_total;
        wait_done(n);
        n_cmp++;
        if (n !== 27) begin
            n_bad++;
            $display("FAIL zero_latency got %0d want 27", n);
        end
        n_cmp++;
        if (rst_low_total - low0 !== 0 || cpu_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_rstlow got lows=%0d rst=%b want 0/1",
                     rst_low_total - low0, cpu_reset);
        end
        n_cmp++;
        if ({pass_cnt, fail_cnt, first_fail} !== {4'd1, 4'd0, 4'd0}) begin
            n_bad++;
            $display("FAIL zero_cnt got %h/%h/%h want 1/0/0",
                     pass_cnt, fail_cnt, first_fail);
        end
        cfg_write(2'd1, 4'd0, 32'd1);
    endtask

    task automatic test_reset_mid_run;
        int n;
        int k;
        cfg_write(2'd3, 4'd0, 32'd4);
        cfg_write(2'd2, 4'd1, 32'h23);
        pulse_start();
        k = 0;
        while (cpu_reset !== 1'b0 && k < 100) begin
            tick();
            k++;
        end
        n_cmp++;
        if (k !== 18) begin
            n_bad++;
            $display("FAIL mid_run_entry got %0d want 18", k);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({cpu_reset, cpu_halt, busy, done, imem_we} !== 5'b10000 ||
            {pass_cnt, fail_cnt, first_fail} !== 12'd0) begin
            n_bad++;
            $display("FAIL mid_reset got rst=%b halt=%b busy=%b done=%b we=%b cnt=%h/%h/%h want 1/0/0/0/0 0",
                     cpu_reset, cpu_halt, busy, done, imem_we,
                     pass_cnt, fail_cnt, first_fail);
        end
        tick();
        pulse_start();
        wait_done(n);
        n_cmp++;
        if (n !== 26 || {pass_cnt, fail_cnt} !== 8'd0) begin
            n_bad++;
            $display("FAIL cleared_cfg got lat=%0d cnt=%h/%h want 26 0/0",
                     n, pass_cnt, fail_cnt);
        end
        cfg_write(2'd3, 4'd0, 32'd4);
        cfg_write(2'd2, 4'd0, 32'h22);
        cfg_write(2'd2, 4'd1, 32'h23);
        pulse_start();
        wait_done(n);
        n_cmp++;
        if (n !== 32 || {pass_cnt, fail_cnt, first_fail} !== {4'd2, 8'd0}) begin
            n_bad++;
            $display("FAIL after_reset got lat=%0d cnt=%h/%h/%h want 32 2/0/0",
                     n, pass_cnt, fail_cnt, first_fail);
        end
    endtask

    task automatic test_start_during_load;
        int n;
        int we0;
        we0 = we_total;
        pulse_start();
        tick(); tick(); tick();
        start = 1'b1;
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_addr = 4'd0;
        cfg_wdata = 32'hDEADBEEF;
        tick();
        start = 1'b0;
        cfg_we = 1'b0;
        wait_done(n);
        n_cmp++;
        if (n + 4 !== 32 || we_total - we0 !== 16) begin
            n_bad++;
            $display("FAIL load_ignore got lat=%0d writes=%0d want 32/16",
                     n + 4, we_total - we0);
        end
        n_cmp++;
        if ({pass_cnt, fail_cnt} !== {4'd2, 4'd0}) begin
            n_bad++;
            $display("FAIL load_cnt got %h/%h want 2/0", pass_cnt, fail_cnt);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int we0;
        we0 = we_total;
        pulse_start();
        wait_done(n);
        n_cmp++;
        if (imem_m[0] !== ADDI || we_total - we0 !== 16 || n !== 32) begin
            n_bad++;
            $display("FAIL replay got w0=%h writes=%0d lat=%0d want %h/16/32",
                     imem_m[0], we_total - we0, n, ADDI);
        end
        n_cmp++;
        if ({pass_cnt, fail_cnt, first_fail} !== {4'd2, 8'd0}) begin
            n_bad++;
            $display("FAIL replay_cnt got %h/%h/%h want 2/0/0",
                     pass_cnt, fail_cnt, first_fail);
        end
    endtask

    task automatic test_all_disabled;
        int n;
        cfg_write(2'd2, 4'd0, 32'h02);
        cfg_write(2'd2, 4'd1, 32'h03);
        cfg_write(2'd2, 4'd8, 32'h22);
        pulse_start();
        wait_done(n);
        n_cmp++;
        if (n !== 30) begin
            n_bad++;
            $display("FAIL dis_latency got %0d want 30", n);
        end
        n_cmp++;
        if ({pass_cnt, fail_cnt, first_fail, done} !== {12'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL dis_cnt got %h/%h/%h done=%b want 0/0/0 1",
                     pass_cnt, fail_cnt, first_fail, done);
        end
    endtask

    initial begin
        reset = 1'b1;
        cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0;
        test_reset();
        for (int i = 0; i < 8; i++) begin
            cfg_write(2'd2, 4'(i), 32'd0);
            cfg_write(2'd1, 4'(i), 32'd0);
        end
        cfg_write(2'd0, 4'd0, ADDI);
        cfg_write(2'd0, 4'd1, ADD);
        for (int i = 2; i < 16; i++) cfg_write(2'd0, 4'(i), NOP);
        test_pass();
        test_fail_entry();
        test_zero_run();
        test_reset_mid_run();
        test_start_during_load();
        test_back_to_back();
        test_all_disabled();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
